dyn_phase_sched: RTL
====================

Name: dyn_phase_sched

Overview:
Multi-step scheduler for the PLL dynamic phase-shift port.
- Accepts a signed target phase position for one PLL output counter (C0..C4) over a valid/ready request interface.
- Tracks the current position of each counter, then issues the single steps needed to reach the target, one at a time, each fully handshaked on PHASEDONE.
- Sits between the register block and the PLL phasestep/phaseupdown/phasecounterselect/phasedone pins. Reports busy, done and error status.

Parameters:
P_PHW, 8, width of signed phase-position registers and target (two's complement)
P_NCNT, 5, number of tracked output counters (C0..C4, select codes 2..6)
P_STEP_CYC, 2, cycles PHASESTEP is held high per step (min 2)
P_TOW, 10, width of the timeout counter; timeout = 2**P_TOW-1 cycles

Ports:
CLK50M  in  1  system clock, 50 MHz
RESET_N  in  1  reset; asynchronous assert, active-low
REQ_VALID  in  1  request strobe
REQ_READY  out  1  high in IDLE only
REQ_COUNTER  in  4  counter select; 2..6 = C0..C4, all other values invalid
REQ_TARGET  in  P_PHW  signed target position for the selected counter
ABORT  in  1  stop after the in-flight step completes
BUSY  out  1  high from request accept until DONE
DONE  out  1  one-cycle pulse at request end
ERR_CODE  out  2  0=OK, 1=BADSEL, 2=TIMEOUT, 3=ABORTED; valid with DONE, held until next accept
RD_COUNTER  in  4  readback select
RD_POS  out  P_PHW  current tracked position of RD_COUNTER (0 if invalid); combinational
PHASEDONE  in  1  PLL step-complete, high when idle; double-synchronised inside
PHASECOUNTERSELECT  out  4  to PLL
PHASEUPDOWN  out  1  to PLL; 1=up, 0=down
PHASESTEP  out  1  to PLL

Behaviour:
- Reset values: REQ_READY=0 during reset, 1 after the first edge. BUSY=0, DONE=0, ERR_CODE=0, PHASESTEP=0, PHASEUPDOWN=0, PHASECOUNTERSELECT=0, all positions=0, FSM=IDLE.
- Handshake: a request is accepted on a cycle where REQ_VALID&&REQ_READY. REQ_COUNTER and REQ_TARGET are latched at accept. BUSY rises the next cycle.
- States: IDLE, CHECK, SETUP, STEP, WAIT_LO, WAIT_HI, FINISH.
- IDLE: on accept -> CHECK.
- CHECK: transitions evaluated in this priority order:
  - invalid select -> FINISH with BADSEL; no PLL activity.
  - ABORT high -> FINISH with ABORTED.
  - delta = target - pos, computed at P_PHW+1 bits; if delta==0 -> FINISH with OK.
  - otherwise -> SETUP.
- SETUP (1 cycle): drive PHASECOUNTERSELECT=latched select and PHASEUPDOWN=(delta>0). PHASESTEP stays 0, giving one cycle of setup before the step.
- STEP: PHASESTEP=1 for exactly P_STEP_CYC cycles; select and updown held stable -> WAIT_LO.
- WAIT_LO: PHASESTEP=0; waits for synchronised PHASEDONE==0 -> WAIT_HI.
- WAIT_HI: waits for synchronised PHASEDONE==1.
  - On the rising edge, pos[sel] increments by 1 (up) or decrements by 1 (down), then -> CHECK.
  - Each step is one PLL phase increment; positions wrap modulo 2**P_PHW with no saturation. Targets are always reachable because delta uses the P_PHW+1-bit width.
- Timeout: the counter clears on entry to WAIT_LO and WAIT_HI. If it hits all-ones in either state -> FINISH with TIMEOUT; the position is not updated. PHASECOUNTERSELECT and PHASEUPDOWN return to 0.
- FINISH (1 cycle):
  - DONE=1 and ERR_CODE set; BUSY drops in the same cycle; -> IDLE.
  - PHASEUPDOWN=0 and PHASECOUNTERSELECT=0 are restored.
- ABORT:
  - sampled only in CHECK, so an in-flight step always completes and its position is committed;
  - ABORT in IDLE is ignored.
- REQ_VALID while busy: REQ_READY=0, so the request is held off; no queueing.
- Reset mid-operation: PHASESTEP drops immediately and positions clear to 0. Software must re-home by reprogramming the PLL.
- Latency for a 1-step request with PHASEDONE responding in L_lo/L_hi cycles: 1 (CHECK) + 1 (SETUP) + P_STEP_CYC + 2 (sync) + L_lo + L_hi + 1 (CHECK) + 1 (FINISH).

Decomposition:
- Package dyn_phase_pkg holds:
  - the state enum;
  - ERR_OK/ERR_BADSEL/ERR_TIMEOUT/ERR_ABORTED;
  - select constants SEL_ALL=0, SEL_M=1, SEL_C0=2..SEL_C4=6;
  - the PHASE_UP=1 / PHASE_DOWN=0 constants.
- One sub-module, dyn_phase_posbank:
  - P_NCNT x P_PHW position registers with async reset;
  - one write port (sel, inc/dec enable) and two read ports (scheduler, RD_POS);
  - select-to-index decode, with an out-of-range flag.

Test Plan:
- Target C1 (sel 3) to +3 from 0, PLL model drops PHASEDONE 3 cycles after PHASESTEP falls and raises it 4 cycles later -> exactly 3 PHASESTEP pulses, each 2 cycles wide. PHASEUPDOWN=1 and PHASECOUNTERSELECT=3 are stable one cycle before and throughout each pulse. DONE with ERR=0; RD_POS(3)=3.
- Then target C1 to -2 -> 5 pulses with PHASEUPDOWN=0; RD_POS(3)=-2 (0xFE); RD_POS(2)=0 unchanged.
- REQ_COUNTER=0 and REQ_COUNTER=7 -> no PHASESTEP, DONE within 3 cycles of accept, ERR=BADSEL (1).
- Target C0 to +5, assert ABORT during the 2nd step's WAIT_HI -> the 2nd step completes, no 3rd pulse, ERR=ABORTED (3), RD_POS(2)=2.
- PLL model never drops PHASEDONE -> DONE 1023 cycles after WAIT_LO entry, ERR=TIMEOUT (2), position unchanged, PHASESTEP=0.
- Deassert RESET_N during STEP -> PHASESTEP=0 asynchronously, BUSY=0, all RD_POS=0; REQ_READY=1 one cycle after release.

Source files
------------

// File: rtl/dyn_phase_pkg.sv
// ---------------------------------------------------------------------------
// dyn_phase_pkg
// Shared definitions for the PLL dynamic phase-shift scheduler.
// - schedState_t : scheduler FSM states
// - ERR_*        : completion status codes reported on ERR_CODE
// - SEL_*        : PLL PHASECOUNTERSELECT encodings (C0..C4 are 2..6)
// - PHASE_UP/DOWN: PHASEUPDOWN encodings
// ---------------------------------------------------------------------------
package dyn_phase_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_SETUP,
      ST_STEP,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_FINISH
   } schedState_t;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_BADSEL  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ABORTED = 2'd3;

   localparam logic [3:0] SEL_ALL = 4'd0;
   localparam logic [3:0] SEL_M   = 4'd1;
   localparam logic [3:0] SEL_C0  = 4'd2;
   localparam logic [3:0] SEL_C1  = 4'd3;
   localparam logic [3:0] SEL_C2  = 4'd4;
   localparam logic [3:0] SEL_C3  = 4'd5;
   localparam logic [3:0] SEL_C4  = 4'd6;

   localparam logic PHASE_UP   = 1'b1;
   localparam logic PHASE_DOWN = 1'b0;

endpackage

// File: rtl/dyn_phase_posbank.sv
// ---------------------------------------------------------------------------
// dyn_phase_posbank
// Bank of P_NCNT signed phase-position registers, one per PLL output counter.
// Counters are addressed by their PLL select code (SEL_C0 upward); any code
// outside that window is out of range.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   wrSel_i/wrEn_i/wrUp_i  : single write port, +1 (up) or -1 (down) step
//   schedSel_i             : scheduler read select
//   schedPos_o/schedValid_o: scheduler read data and in-range flag
//   rdSel_i/rdPos_o        : readback port (0 when out of range)
// ---------------------------------------------------------------------------
module dyn_phase_posbank
   import dyn_phase_pkg::*;
#(
   parameter int P_PHW  = 8,
   parameter int P_NCNT = 5
)(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [3:0]       wrSel_i,
   input  logic             wrEn_i,
   input  logic             wrUp_i,
   input  logic [3:0]       schedSel_i,
   output logic [P_PHW-1:0] schedPos_o,
   output logic             schedValid_o,
   input  logic [3:0]       rdSel_i,
   output logic [P_PHW-1:0] rdPos_o
);

   localparam logic [3:0]       SEL_LAST = 4'(int'(SEL_C0) + P_NCNT - 1);
   localparam logic [P_PHW-1:0] POS_ONE  = P_PHW'(1);

   logic [P_PHW-1:0] pos_q [P_NCNT];
   logic [3:0]       wrIdx;
   logic [3:0]       schedIdx;
   logic [3:0]       rdIdx;
   logic             wrValid;
   logic             rdValid;

   function automatic logic selInRange(input logic [3:0] sel);
      return (sel >= SEL_C0) && (sel <= SEL_LAST);
   endfunction

   // Translate PLL select codes into bank indices and flag anything that
   // does not name one of the tracked output counters.
   always_comb begin
      wrIdx        = wrSel_i - SEL_C0;
      schedIdx     = schedSel_i - SEL_C0;
      rdIdx        = rdSel_i - SEL_C0;
      wrValid      = selInRange(wrSel_i);
      schedValid_o = selInRange(schedSel_i);
      rdValid      = selInRange(rdSel_i);
   end

   // Each completed PLL step moves the tracked position by exactly one.
   // Positions wrap modulo 2**P_PHW, matching the PLL which has no notion
   // of an end stop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < P_NCNT; i++) begin
            pos_q[i] <= '0;
         end
      end else if (wrEn_i && wrValid) begin
         for (int i = 0; i < P_NCNT; i++) begin
            if (wrIdx == 4'(i)) begin
               pos_q[i] <= wrUp_i ? pos_q[i] + POS_ONE : pos_q[i] - POS_ONE;
            end
         end
      end
   end

   // Two independent read muxes; an out-of-range select reads as zero.
   always_comb begin
      schedPos_o = '0;
      rdPos_o    = '0;
      for (int i = 0; i < P_NCNT; i++) begin
         if (schedValid_o && schedIdx == 4'(i)) begin
            schedPos_o = pos_q[i];
         end
         if (rdValid && rdIdx == 4'(i)) begin
            rdPos_o = pos_q[i];
         end
      end
   end

endmodule

// File: rtl/dyn_phase_sched.sv
// ---------------------------------------------------------------------------
// dyn_phase_sched
// Multi-step scheduler for the PLL dynamic phase-shift port. Takes a signed
// target position for one output counter, then walks the PLL there one
// handshaked step at a time, tracking every counter's current position.
// Ports:
//   CLK50M, RESET_N            : clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY        : request handshake (ready only when idle)
//   REQ_COUNTER/REQ_TARGET     : select code (2..6 = C0..C4) and target
//   ABORT                      : stop at the next step boundary
//   BUSY/DONE/ERR_CODE         : status; ERR_CODE valid with DONE
//   RD_COUNTER/RD_POS          : combinational position readback
//   PHASEDONE                  : PLL step-complete (asynchronous)
//   PHASECOUNTERSELECT/PHASEUPDOWN/PHASESTEP : PLL control pins
// ---------------------------------------------------------------------------
module dyn_phase_sched
   import dyn_phase_pkg::*;
#(
   parameter int P_PHW      = 8,
   parameter int P_NCNT     = 5,
   parameter int P_STEP_CYC = 2,
   parameter int P_TOW      = 10
)(
   input  logic             CLK50M,
   input  logic             RESET_N,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [3:0]       REQ_COUNTER,
   input  logic [P_PHW-1:0] REQ_TARGET,
   input  logic             ABORT,
   output logic             BUSY,
   output logic             DONE,
   output logic [1:0]       ERR_CODE,
   input  logic [3:0]       RD_COUNTER,
   output logic [P_PHW-1:0] RD_POS,
   input  logic             PHASEDONE,
   output logic [3:0]       PHASECOUNTERSELECT,
   output logic             PHASEUPDOWN,
   output logic             PHASESTEP
);

   localparam int               SCW       = $clog2(P_STEP_CYC);
   localparam logic [SCW-1:0]   STEP_LAST = SCW'(P_STEP_CYC - 1);
   localparam logic [SCW-1:0]   STEP_ONE  = SCW'(1);
   localparam logic [P_TOW-1:0] TO_LAST   = P_TOW'((2 ** P_TOW) - 2);
   localparam logic [P_TOW-1:0] TO_ONE    = P_TOW'(1);

   schedState_t        state_q;
   logic [3:0]         reqSel_q;
   logic [P_PHW-1:0]   reqTarget_q;
   logic [SCW-1:0]     stepCnt_q;
   logic [P_TOW-1:0]   to_q;
   logic               pdMeta_q;
   logic               pdSync_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;
   logic [1:0]         err_q;
   logic               step_q;
   logic               upDown_q;
   logic [3:0]         cntSel_q;

   logic [P_PHW-1:0]   schedPos;
   logic               selValid;
   logic signed [P_PHW:0] delta;
   logic               deltaZero;
   logic               deltaUp;
   logic               posWrEn;
   logic               accept;

   // Position bank: written once per completed PLL step, read by the
   // scheduler for the latched counter and by software for readback.
   dyn_phase_posbank #(
      .P_PHW  (P_PHW),
      .P_NCNT (P_NCNT)
   ) uPosBank (
      .clk_i        (CLK50M),
      .rst_ni       (RESET_N),
      .wrSel_i      (reqSel_q),
      .wrEn_i       (posWrEn),
      .wrUp_i       (upDown_q),
      .schedSel_i   (reqSel_q),
      .schedPos_o   (schedPos),
      .schedValid_o (selValid),
      .rdSel_i      (RD_COUNTER),
      .rdPos_o      (RD_POS)
   );

   // Distance to target is taken one bit wider than the positions so that
   // every target is reachable without the subtraction wrapping; the sign
   // bit then directly gives the step direction.
   always_comb begin
      delta     = $signed({reqTarget_q[P_PHW-1], reqTarget_q})
                - $signed({schedPos[P_PHW-1], schedPos});
      deltaZero = (delta == '0);
      deltaUp   = ~delta[P_PHW];
      accept    = REQ_VALID && ready_q;
      posWrEn   = (state_q == ST_WAIT_HI) && pdSync_q;
   end

   // PHASEDONE comes from the PLL clock domain; two flops before use. It
   // idles high, so the synchroniser resets high to avoid a false low.
   always_ff @(posedge CLK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         pdMeta_q <= 1'b1;
         pdSync_q <= 1'b1;
      end else begin
         pdMeta_q <= PHASEDONE;
         pdSync_q <= pdMeta_q;
      end
   end

   // Scheduler FSM. All PLL-facing and status outputs are registered and
   // updated on the transition into the state that needs them, so e.g.
   // DONE/ERR_CODE are set on the edge that enters FINISH and the select
   // and direction are already stable during the SETUP cycle. ABORT is
   // only looked at in CHECK, so a step that has started always finishes
   // and its position is committed before the request ends.
   always_ff @(posedge CLK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         reqSel_q    <= SEL_ALL;
         reqTarget_q <= '0;
         stepCnt_q   <= '0;
         to_q        <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= ERR_OK;
         step_q      <= 1'b0;
         upDown_q    <= PHASE_DOWN;
         cntSel_q    <= SEL_ALL;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  reqSel_q    <= REQ_COUNTER;
                  reqTarget_q <= REQ_TARGET;
                  busy_q      <= 1'b1;
                  ready_q     <= 1'b0;
                  err_q       <= ERR_OK;
                  state_q     <= ST_CHECK;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_CHECK: begin
               if (!selValid) begin
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  err_q    <= ERR_BADSEL;
                  upDown_q <= PHASE_DOWN;
                  cntSel_q <= SEL_ALL;
                  state_q  <= ST_FINISH;
               end else if (ABORT) begin
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  err_q    <= ERR_ABORTED;
                  upDown_q <= PHASE_DOWN;
                  cntSel_q <= SEL_ALL;
                  state_q  <= ST_FINISH;
               end else if (deltaZero) begin
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  err_q    <= ERR_OK;
                  upDown_q <= PHASE_DOWN;
                  cntSel_q <= SEL_ALL;
                  state_q  <= ST_FINISH;
               end else begin
                  cntSel_q <= reqSel_q;
                  upDown_q <= deltaUp ? PHASE_UP : PHASE_DOWN;
                  state_q  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               step_q    <= 1'b1;
               stepCnt_q <= '0;
               state_q   <= ST_STEP;
            end
            ST_STEP: begin
               if (stepCnt_q == STEP_LAST) begin
                  step_q  <= 1'b0;
                  to_q    <= '0;
                  state_q <= ST_WAIT_LO;
               end else begin
                  stepCnt_q <= stepCnt_q + STEP_ONE;
               end
            end
            ST_WAIT_LO: begin
               if (!pdSync_q) begin
                  to_q    <= '0;
                  state_q <= ST_WAIT_HI;
               end else if (to_q == TO_LAST) begin
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  err_q    <= ERR_TIMEOUT;
                  upDown_q <= PHASE_DOWN;
                  cntSel_q <= SEL_ALL;
                  state_q  <= ST_FINISH;
               end else begin
                  to_q <= to_q + TO_ONE;
               end
            end
            ST_WAIT_HI: begin
               if (pdSync_q) begin
                  state_q <= ST_CHECK;
               end else if (to_q == TO_LAST) begin
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  err_q    <= ERR_TIMEOUT;
                  upDown_q <= PHASE_DOWN;
                  cntSel_q <= SEL_ALL;
                  state_q  <= ST_FINISH;
               end else begin
                  to_q <= to_q + TO_ONE;
               end
            end
            ST_FINISH: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign REQ_READY          = ready_q;
   assign BUSY               = busy_q;
   assign DONE               = done_q;
   assign ERR_CODE           = err_q;
   assign PHASESTEP          = step_q;
   assign PHASEUPDOWN        = upDown_q;
   assign PHASECOUNTERSELECT = cntSel_q;

endmodule
